// File: rtl/vector_stream_feeder.sv
// vector_stream_feeder: paced operand reader feeding paired N-lane vectors to the multiplier
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   start, hold                 launch request (IDLE only), issue stall
//   base_addr0/1, len           first addresses and beat count, latched at start
//   mem0/1_rd_en, mem0/1_addr   read strobes and addresses to the operand memories
//   mem0/1_rd_data              read data, valid RD_LAT cycles after the strobe
//   out0, out1                  operand vectors, lane i at [i*bitwidth +: bitwidth]
//   out_valid, out_last         beat qualifier and final-beat tag
//   busy, done                  run in progress, one-cycle completion pulse
module vector_stream_feeder #(
    parameter int bitwidth = 16,
    parameter int N        = 8,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  hold,
    input  logic [ADDR_W-1:0]     base_addr0,
    input  logic [ADDR_W-1:0]     base_addr1,
    input  logic [LEN_W-1:0]      len,
    output logic                  mem0_rd_en,
    output logic                  mem1_rd_en,
    output logic [ADDR_W-1:0]     mem0_addr,
    output logic [ADDR_W-1:0]     mem1_addr,
    input  logic [N*bitwidth-1:0] mem0_rd_data,
    input  logic [N*bitwidth-1:0] mem1_rd_data,
    output logic [N*bitwidth-1:0] out0,
    output logic [N*bitwidth-1:0] out1,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3;
    logic [1:0]        state;
    logic [LEN_W-1:0]  len_r, cnt;
    logic [RD_LAT-1:0] vsr, lsr;
    logic              rd_en, final_issue;
    assign rd_en       = state == ISSUE && !hold;
    assign final_issue = rd_en && cnt == len_r - LEN_W'(1);
    assign mem0_rd_en  = rd_en;
    assign mem1_rd_en  = rd_en;
    // busy starts with the first actual issue (a start held off by hold is not busy yet)
    // and stays up through the out_last cycle, which coincides with FIN
    assign busy = (state == ISSUE && (cnt != '0 || !hold)) || state == DRAIN || out_last;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            len_r     <= '0;
            cnt       <= '0;
            vsr       <= '0;
            lsr       <= '0;
            mem0_addr <= '0;
            mem1_addr <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            vsr       <= (vsr << 1) | RD_LAT'(rd_en);
            lsr       <= (lsr << 1) | RD_LAT'(final_issue);
            out_valid <= vsr[RD_LAT-1];
            out_last  <= lsr[RD_LAT-1];
            done      <= state == FIN;
            if (vsr[RD_LAT-1]) begin
                out0 <= mem0_rd_data;
                out1 <= mem1_rd_data;
            end
            if (rd_en) begin
                mem0_addr <= mem0_addr + 1'b1;
                mem1_addr <= mem1_addr + 1'b1;
                cnt       <= cnt + 1'b1;
            end
            if (state == IDLE && start) begin
                mem0_addr <= base_addr0;
                mem1_addr <= base_addr1;
                len_r     <= len;
                cnt       <= '0;
                state     <= len != '0 ? ISSUE : FIN;
            end else if (state == ISSUE && final_issue) begin
                state <= DRAIN;
            end else if (state == DRAIN && lsr[RD_LAT-1]) begin
                // last beat enters the output register now; done follows it by one cycle
                state <= FIN;
            end else if (state == FIN) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vector_stream_feeder.sv
// tb_vector_stream_feeder: directed checks of the vector stream feeder at two configurations
module tb_vector_stream_feeder;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;

    function automatic logic [127:0] pat(input bit s, input int a);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(a * 8 + i) ^ (s ? 16'hA000 : 16'h5000);
        return r;
    endfunction

    logic a_start = 0, a_hold = 0, a_rd0, a_rd1, a_v, a_l, a_busy, a_done;
    logic [9:0] a_b0 = 0, a_b1 = 0, a_ad0, a_ad1;
    logic [15:0] a_len = 0;
    logic [127:0] a_d0, a_d1, a_o0, a_o1;
    vector_stream_feeder #(.RD_LAT(1), .ADDR_W(10)) dut_a (
        .clk(clk), .rstn(rstn), .start(a_start), .hold(a_hold),
        .base_addr0(a_b0), .base_addr1(a_b1), .len(a_len),
        .mem0_rd_en(a_rd0), .mem1_rd_en(a_rd1), .mem0_addr(a_ad0), .mem1_addr(a_ad1),
        .mem0_rd_data(a_d0), .mem1_rd_data(a_d1), .out0(a_o0), .out1(a_o1),
        .out_valid(a_v), .out_last(a_l), .busy(a_busy), .done(a_done));

    logic b_start = 0, b_hold = 0, b_rd0, b_rd1, b_v, b_l, b_busy, b_done;
    logic [3:0] b_b0 = 0, b_b1 = 0, b_ad0, b_ad1;
    logic [15:0] b_len = 0;
    logic [127:0] b_s0, b_s1, b_t0, b_t1, b_d0, b_d1, b_o0, b_o1;
    vector_stream_feeder #(.RD_LAT(3), .ADDR_W(4)) dut_b (
        .clk(clk), .rstn(rstn), .start(b_start), .hold(b_hold),
        .base_addr0(b_b0), .base_addr1(b_b1), .len(b_len),
        .mem0_rd_en(b_rd0), .mem1_rd_en(b_rd1), .mem0_addr(b_ad0), .mem1_addr(b_ad1),
        .mem0_rd_data(b_d0), .mem1_rd_data(b_d1), .out0(b_o0), .out1(b_o1),
        .out_valid(b_v), .out_last(b_l), .busy(b_busy), .done(b_done));

    always @(posedge clk) begin
        if (a_rd0) a_d0 <= pat(0, int'(a_ad0));
        if (a_rd1) a_d1 <= pat(1, int'(a_ad1));
        if (b_rd0) b_s0 <= pat(0, int'(b_ad0));
        if (b_rd1) b_t0 <= pat(1, int'(b_ad1));
        b_s1 <= b_s0;
        b_t1 <= b_t0;
        b_d0 <= b_s1;
        b_d1 <= b_t1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({a_rd0, a_rd1, a_v, a_l, a_busy, a_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a got %b want 000000", {a_rd0, a_rd1, a_v, a_l, a_busy, a_done});
        end
        checks++;
        if (a_ad0 !== 10'd0 || a_ad1 !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr_a got %h/%h want 0/0", a_ad0, a_ad1);
        end
        checks++;
        if (a_o0 !== 128'd0 || a_o1 !== 128'd0) begin
            errors++;
            $display("FAIL reset_data_a got %h/%h want 0", a_o0, a_o1);
        end
        checks++;
        if ({b_rd0, b_v, b_l, b_busy, b_done, b_ad0} !== 9'b0) begin
            errors++;
            $display("FAIL reset_b got %b want 0", {b_rd0, b_v, b_l, b_busy, b_done, b_ad0});
        end
    endtask

    task automatic test_basic();
        a_b0 = 10'h000; a_b1 = 10'h100; a_len = 4; a_start = 1;
        step();
        a_start = 0;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (a_rd0 !== (c <= 4) || a_rd1 !== (c <= 4)) begin
                errors++;
                $display("FAIL basic_rd c=%0d got %b%b want %b", c, a_rd0, a_rd1, c <= 4);
            end
            if (c <= 4) begin
                checks++;
                if (a_ad0 !== 10'(c - 1) || a_ad1 !== 10'(256 + c - 1)) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d got %h/%h want %h/%h", c, a_ad0, a_ad1, 10'(c - 1), 10'(256 + c - 1));
                end
            end
            checks++;
            if (a_v !== (c >= 3 && c <= 6) || a_l !== (c == 6) || a_done !== (c == 7) || a_busy !== (c <= 6)) begin
                errors++;
                $display("FAIL basic_ctl c=%0d got v%b l%b d%b b%b want v%b l%b d%b b%b", c, a_v, a_l, a_done, a_busy,
                         c >= 3 && c <= 6, c == 6, c == 7, c <= 6);
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (a_o0 !== pat(0, c - 3) || a_o1 !== pat(1, 256 + c - 3)) begin
                    errors++;
                    $display("FAIL basic_data c=%0d got %h/%h want %h/%h", c, a_o0, a_o1, pat(0, c - 3), pat(1, 256 + c - 3));
                end
            end
            a_start = (c == 2);
            step();
        end
        a_start = 0;
    endtask

    task automatic test_hold();
        int rk, bk;
        a_b0 = 10'h020; a_b1 = 10'h3FE; a_len = 3; a_start = 1;
        step();
        a_start = 0;
        for (int c = 1; c <= 9; c++) begin
            a_hold = (c == 2 || c == 3);
            #1;
            rk = (c == 1) ? 0 : c - 3;
            bk = (c == 3) ? 0 : c - 5;
            checks++;
            if (a_rd0 !== (c == 1 || c == 4 || c == 5)) begin
                errors++;
                $display("FAIL hold_rd c=%0d got %b want %b", c, a_rd0, c == 1 || c == 4 || c == 5);
            end
            if (c == 1 || c == 4 || c == 5) begin
                checks++;
                if (a_ad0 !== 10'(32 + rk) || a_ad1 !== 10'(1022 + rk)) begin
                    errors++;
                    $display("FAIL hold_addr c=%0d got %h/%h want %h/%h", c, a_ad0, a_ad1, 10'(32 + rk), 10'(1022 + rk));
                end
            end
            checks++;
            if (a_v !== (c == 3 || c == 6 || c == 7) || a_l !== (c == 7) || a_done !== (c == 8) || a_busy !== (c <= 7)) begin
                errors++;
                $display("FAIL hold_ctl c=%0d got v%b l%b d%b b%b", c, a_v, a_l, a_done, a_busy);
            end
            if (c == 3 || c == 6 || c == 7) begin
                checks++;
                if (a_o0 !== pat(0, 32 + bk) || a_o1 !== pat(1, (1022 + bk) % 1024)) begin
                    errors++;
                    $display("FAIL hold_data c=%0d got %h/%h want %h/%h", c, a_o0, a_o1, pat(0, 32 + bk), pat(1, (1022 + bk) % 1024));
                end
            end
            step();
        end
        a_hold = 0;
    endtask

    task automatic test_zero_len();
        a_len = 0; a_start = 1;
        step();
        a_start = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (a_rd0 !== 1'b0 || a_v !== 1'b0 || a_busy !== 1'b0 || a_done !== (c == 2)) begin
                errors++;
                $display("FAIL zero_len c=%0d got rd%b v%b b%b d%b want rd0 v0 b0 d%b", c, a_rd0, a_v, a_busy, a_done, c == 2);
            end
            step();
        end
    endtask

    task automatic test_lat3();
        b_b0 = 4'd5; b_b1 = 4'd9; b_len = 1; b_start = 1;
        step();
        b_start = 0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (b_rd0 !== (c == 1) || b_v !== (c == 5) || b_l !== (c == 5) || b_done !== (c == 6) || b_busy !== (c <= 5)) begin
                errors++;
                $display("FAIL lat3_ctl c=%0d got rd%b v%b l%b d%b b%b", c, b_rd0, b_v, b_l, b_done, b_busy);
            end
            if (c == 5) begin
                checks++;
                if (b_o0 !== pat(0, 5) || b_o1 !== pat(1, 9)) begin
                    errors++;
                    $display("FAIL lat3_data got %h/%h want %h/%h", b_o0, b_o1, pat(0, 5), pat(1, 9));
                end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        b_b0 = 4'd14; b_b1 = 4'd3; b_len = 4; b_start = 1;
        step();
        b_start = 0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (b_rd0 !== (c <= 4) || b_v !== (c >= 5 && c <= 8) || b_l !== (c == 8) || b_done !== (c == 9) || b_busy !== (c <= 8)) begin
                errors++;
                $display("FAIL wrap_ctl c=%0d got rd%b v%b l%b d%b b%b", c, b_rd0, b_v, b_l, b_done, b_busy);
            end
            if (c <= 4) begin
                checks++;
                if (b_ad0 !== 4'(13 + c) || b_ad1 !== 4'(2 + c)) begin
                    errors++;
                    $display("FAIL wrap_addr c=%0d got %0d/%0d want %0d/%0d", c, b_ad0, b_ad1, 4'(13 + c), 4'(2 + c));
                end
            end
            if (c >= 5 && c <= 8) begin
                checks++;
                if (b_o0 !== pat(0, (9 + c) % 16) || b_o1 !== pat(1, c - 2)) begin
                    errors++;
                    $display("FAIL wrap_data c=%0d got %h/%h want %h/%h", c, b_o0, b_o1, pat(0, (9 + c) % 16), pat(1, c - 2));
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        a_b0 = 10'h040; a_b1 = 10'h000; a_len = 8; a_start = 1;
        step();
        a_start = 0;
        step();
        step();
        checks++;
        if (a_v !== 1'b1 || a_rd0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got v%b rd%b want v1 rd1", a_v, a_rd0);
        end
        rstn = 0;
        #1;
        checks++;
        if ({a_rd0, a_v, a_l, a_busy, a_done} !== 5'b0 || a_ad0 !== 10'd0 || a_o0 !== 128'd0 || a_o1 !== 128'd0) begin
            errors++;
            $display("FAIL mid_reset got rd%b v%b l%b b%b d%b addr%h out%h", a_rd0, a_v, a_l, a_busy, a_done, a_ad0, a_o0);
        end
        step();
        rstn = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (a_v !== 1'b0 || a_rd0 !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_after c=%0d got v%b rd%b b%b want 0", c, a_v, a_rd0, a_busy);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1;
        step();
        test_basic();
        test_hold();
        test_zero_len();
        test_lat3();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
